// File: rtl/mimo_branch_merge_8.sv
// mimo_branch_merge_8: merges eight valid-only branches into one ready/valid
// stream through per-lane FIFOs drained round-robin; each output word is
// tagged with its source lane.
// Optional build macro MIMO_MERGE_DROP_COUNT_EN adds o_drop_count, a
// saturating total of dropped words.
module mimo_branch_merge_8 #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LANE_DEPTH = 16,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  input  logic [WIDTH-1:0] i_data_4,
  input  logic [WIDTH-1:0] i_data_5,
  input  logic [WIDTH-1:0] i_data_6,
  input  logic [WIDTH-1:0] i_data_7,
  input  logic             i_valid_0,
  input  logic             i_valid_1,
  input  logic             i_valid_2,
  input  logic             i_valid_3,
  input  logic             i_valid_4,
  input  logic             i_valid_5,
  input  logic             i_valid_6,
  input  logic             i_valid_7,
  output logic [WIDTH-1:0] o_data,
  output logic [2:0]       o_branch,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_almost_full,
  output logic [7:0]       o_overflow
`ifdef MIMO_MERGE_DROP_COUNT_EN
  ,
  output logic [15:0]      o_drop_count
`endif
);

  localparam int unsigned NL = 8;
  localparam int unsigned AW = $clog2(LANE_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LANE_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(LANE_DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] din [NL];
  logic [NL-1:0]    vin;

  logic [WIDTH-1:0] mem    [NL][LANE_DEPTH];
  logic [AW-1:0]    wr_ptr [NL];
  logic [AW-1:0]    rd_ptr [NL];
  logic [CW-1:0]    cnt    [NL];
  logic [CW-1:0]    cnt_nxt[NL];

  logic [NL-1:0] full;
  logic [NL-1:0] nempty;
  logic [NL-1:0] push;
  logic [NL-1:0] pop;
  logic [NL-1:0] drop;
  logic [2:0]    rr;
  logic [2:0]    sel;
  logic          any_ne;
  logic          ld;
  logic          af_nxt;

  // Gather the discrete branch ports into lane-indexed arrays
  assign din[0] = i_data_0;
  assign din[1] = i_data_1;
  assign din[2] = i_data_2;
  assign din[3] = i_data_3;
  assign din[4] = i_data_4;
  assign din[5] = i_data_5;
  assign din[6] = i_data_6;
  assign din[7] = i_data_7;
  assign vin = {i_valid_7, i_valid_6, i_valid_5, i_valid_4,
                i_valid_3, i_valid_2, i_valid_1, i_valid_0};

  // Output register may load when empty or being consumed this edge
  assign ld = !o_valid || i_ready;

  // Lane status flags from current occupancy
  always_comb begin
    full   = '0;
    nempty = '0;
    for (int k = 0; k < NL; k++) begin
      full[k]   = (cnt[k] == FULL_CNT);
      nempty[k] = (cnt[k] != '0);
    end
  end

  // Round-robin arbiter: first non-empty lane starting at rr
  always_comb begin
    logic [2:0] idx;
    idx    = rr;
    sel    = '0;
    any_ne = 1'b0;
    for (int i = 0; i < NL; i++) begin
      idx = rr + 3'(i);
      if (!any_ne && nempty[idx]) begin
        any_ne = 1'b1;
        sel    = idx;
      end
    end
  end

  // Per-lane push/pop/drop decisions and next occupancy
  always_comb begin
    push   = '0;
    pop    = '0;
    drop   = '0;
    af_nxt = 1'b0;
    for (int k = 0; k < NL; k++) begin
      pop[k]     = ld && any_ne && (sel == 3'(k));
      push[k]    = vin[k] && (!full[k] || pop[k]);
      drop[k]    = vin[k] && full[k] && !pop[k];
      cnt_nxt[k] = cnt[k] + CW'(push[k]) - CW'(pop[k]);
      if (cnt_nxt[k] >= AF_CNT) af_nxt = 1'b1;
    end
  end

  // Lane storage writes; contents are don't-care until pointed at
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < NL; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= din[k];
    end
  end

  // Lane pointers, occupancy, arbiter pointer and registered outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NL; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      rr            <= '0;
      o_data        <= '0;
      o_branch      <= '0;
      o_valid       <= 1'b0;
      o_almost_full <= 1'b0;
      o_overflow    <= '0;
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
        cnt[k] <= cnt_nxt[k];
      end
      if (ld) begin
        if (any_ne) begin
          o_data   <= mem[sel][rd_ptr[sel]];
          o_branch <= sel;
          o_valid  <= 1'b1;
          rr       <= sel + 3'd1;
        end else begin
          o_valid <= 1'b0;
        end
      end
      o_almost_full <= af_nxt;
      o_overflow    <= o_overflow | drop;
    end
  end

`ifdef MIMO_MERGE_DROP_COUNT_EN
  logic [3:0]  n_drop;
  logic [16:0] drop_sum;

  // Number of lanes dropping this cycle and the widened running sum
  always_comb begin
    n_drop = '0;
    for (int k = 0; k < NL; k++) begin
      n_drop = n_drop + 4'(drop[k]);
    end
    drop_sum = {1'b0, o_drop_count} + 17'(n_drop);
  end

  // Saturating total of dropped words
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_drop_count <= '0;
    end else if (drop_sum[16]) begin
      o_drop_count <= 16'hFFFF;
    end else begin
      o_drop_count <= drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_mimo_branch_merge_8.sv
// Self-checking bench for mimo_branch_merge_8: expected (branch, data) pairs
// are queued as stimulus is driven and compared on each output handshake.
module tb_mimo_branch_merge_8;

  typedef struct packed {
    logic [2:0]  br;
    logic [15:0] d;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] din [8];
  logic [7:0]  vin;
  logic        ready;
  logic [15:0] o_data;
  logic [2:0]  o_branch;
  logic        o_valid;
  logic        o_af;
  logic [7:0]  o_ovf;
`ifdef MIMO_MERGE_DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mimo_branch_merge_8 #(.WIDTH(16), .LANE_DEPTH(16), .AF_MARGIN(4)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_data_0     (din[0]),
    .i_data_1     (din[1]),
    .i_data_2     (din[2]),
    .i_data_3     (din[3]),
    .i_data_4     (din[4]),
    .i_data_5     (din[5]),
    .i_data_6     (din[6]),
    .i_data_7     (din[7]),
    .i_valid_0    (vin[0]),
    .i_valid_1    (vin[1]),
    .i_valid_2    (vin[2]),
    .i_valid_3    (vin[3]),
    .i_valid_4    (vin[4]),
    .i_valid_5    (vin[5]),
    .i_valid_6    (vin[6]),
    .i_valid_7    (vin[7]),
    .o_data       (o_data),
    .o_branch     (o_branch),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_almost_full(o_af),
    .o_overflow   (o_ovf)
`ifdef MIMO_MERGE_DROP_COUNT_EN
    ,
    .o_drop_count (drop_cnt)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    vin   = '0;
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= 300), 0);
  endtask

  // Output monitor: a word present with ready at the falling edge is taken at the next rising edge
  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_branch", 32'(o_branch), 32'(e.br));
        chk("out_data", 32'(o_data), 32'(e.d));
      end
    end
  end

  initial begin
    int nv;
    rst_n = 1'b0;
    ready = 1'b1;
    vin   = '0;
    for (int k = 0; k < 8; k++) din[k] = '0;
    step();
    step();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_branch", 32'(o_branch), 0);
    chk("rst_af", 32'(o_af), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    rst_n = 1'b1;

    // 1: idle
    nv = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (o_valid) nv++;
    end
    chk("t1_valid_seen", 32'(nv), 0);
    chk("t1_ovf", 32'(o_ovf), 0);
    chk("t1_af", 32'(o_af), 0);

    // 2: one cycle, all lanes, data = lane index
    for (int k = 0; k < 8; k++) begin
      din[k] = 16'(k);
      exp_q.push_back('{br: 3'(k), d: 16'(k)});
    end
    vin = 8'hFF;
    step();
    vin = '0;
    chk("t2_valid_t", 32'(o_valid), 0);
    step();
    chk("t2_valid_t1", 32'(o_valid), 1);
    chk("t2_first_br", 32'(o_branch), 0);
    wait_drain();

    // 3: lane 3 stalled downstream
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vin[3] = 1'b1;
      din[3] = 16'(16'h10 + i);
      exp_q.push_back('{br: 3'd3, d: 16'(16'h10 + i)});
      step();
    end
    vin = '0;
    step();
    chk("t3_stall_data_a", 32'(o_data), 32'h10);
    repeat (14) step();
    chk("t3_stall_valid", 32'(o_valid), 1);
    chk("t3_stall_data", 32'(o_data), 32'h10);
    chk("t3_stall_br", 32'(o_branch), 3);
    ready = 1'b1;
    wait_drain();

    // 4: lane 5 overflow while stalled
    reset_dut();
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vin[5] = 1'b1;
      din[5] = 16'(i);
      if (i < 17) exp_q.push_back('{br: 3'd5, d: 16'(i)});
      step();
      if (i == 11) chk("t4_af_12w", 32'(o_af), 0);
      if (i == 12) chk("t4_af_13w", 32'(o_af), 1);
    end
    vin = '0;
    chk("t4_ovf", 32'(o_ovf), 32'h20);
`ifdef MIMO_MERGE_DROP_COUNT_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 3);
`endif
    ready = 1'b1;
    wait_drain();
    chk("t4_af_after", 32'(o_af), 0);
    chk("t4_ovf_sticky", 32'(o_ovf), 32'h20);

    // 5: lanes 0 and 7 continuously valid
    reset_dut();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vin[0] = 1'b1;
      vin[7] = 1'b1;
      din[0] = 16'(i);
      din[7] = 16'(16'h700 + i);
      exp_q.push_back('{br: 3'd0, d: 16'(i)});
      exp_q.push_back('{br: 3'd7, d: 16'(16'h700 + i)});
      step();
    end
    vin = '0;
    wait_drain();
    chk("t5_ovf", 32'(o_ovf), 0);

    // 6: async reset mid-drain with 6 words buffered and an overflow flagged
    reset_dut();
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vin[6] = 1'b1;
      din[6] = 16'(16'h60 + i);
      if (i < 17) exp_q.push_back('{br: 3'd6, d: 16'(16'h60 + i)});
      step();
    end
    vin = '0;
    chk("t6_ovf_pre", 32'(o_ovf), 32'h40);
    ready = 1'b1;
    repeat (11) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(o_valid), 0);
    chk("t6_ovf_cleared", 32'(o_ovf), 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_valid) nv++;
    end
    chk("t6_stale_words", 32'(nv), 0);
    chk("t6_af", 32'(o_af), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
